// File: rtl/fss_mem_pkg.sv
// Shared types and default sizing for the FSS BRAM port-A arbiter.
package fss_mem_pkg;

  localparam int unsigned C_DATA_WIDTH    = 16;
  localparam int unsigned C_ADDRESS_WIDTH = 11;
  localparam int unsigned C_WARMUP_CYCLES = 2;
  localparam int unsigned C_MAX_BURST     = 8;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned C_GNT_CPU_BIT = 0;
  localparam int unsigned C_GNT_PER_BIT = 1;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_PER = 1'b1
  } last_gnt_t;

  // Bits needed to hold the value max_value (never less than one).
  function automatic int unsigned count_width(input int unsigned max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/fss_mem_arbiter_if.sv
// Bus bundle between the CR16 core, the peripheral master, the BRAM port A
// and the arbiter. The slave modport is the arbiter's view.
interface fss_mem_arbiter_if
  import fss_mem_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH    = C_DATA_WIDTH,
  parameter int unsigned P_ADDRESS_WIDTH = C_ADDRESS_WIDTH
) ();

  // CR16 core side
  logic                       I_CPU_REQ;
  logic                       I_CPU_WE;
  logic [P_ADDRESS_WIDTH-1:0] I_CPU_ADDR;
  logic [P_DATA_WIDTH-1:0]    I_CPU_WDATA;
  logic                       O_CPU_GNT;
  logic                       O_CPU_RVALID;
  logic [P_DATA_WIDTH-1:0]    O_CPU_RDATA;
  logic                       O_CPU_ENABLE;

  // Peripheral master side (voice engine or program loader)
  logic                       I_PER_REQ;
  logic                       I_PER_WE;
  logic                       I_PER_LOCK;
  logic [P_ADDRESS_WIDTH-1:0] I_PER_ADDR;
  logic [P_DATA_WIDTH-1:0]    I_PER_WDATA;
  logic                       O_PER_GNT;
  logic                       O_PER_RVALID;
  logic [P_DATA_WIDTH-1:0]    O_PER_RDATA;

  // BRAM port A
  logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDR;
  logic [P_DATA_WIDTH-1:0]    O_MEM_WDATA;
  logic                       O_MEM_WE;
  logic [P_DATA_WIDTH-1:0]    I_MEM_RDATA;

  logic                       O_READY;

  modport slave (
    input  I_CPU_REQ, I_CPU_WE, I_CPU_ADDR, I_CPU_WDATA,
    output O_CPU_GNT, O_CPU_RVALID, O_CPU_RDATA, O_CPU_ENABLE,
    input  I_PER_REQ, I_PER_WE, I_PER_LOCK, I_PER_ADDR, I_PER_WDATA,
    output O_PER_GNT, O_PER_RVALID, O_PER_RDATA,
    output O_MEM_ADDR, O_MEM_WDATA, O_MEM_WE,
    input  I_MEM_RDATA,
    output O_READY
  );

  modport master (
    output I_CPU_REQ, I_CPU_WE, I_CPU_ADDR, I_CPU_WDATA,
    input  O_CPU_GNT, O_CPU_RVALID, O_CPU_RDATA, O_CPU_ENABLE,
    output I_PER_REQ, I_PER_WE, I_PER_LOCK, I_PER_ADDR, I_PER_WDATA,
    input  O_PER_GNT, O_PER_RVALID, O_PER_RDATA,
    input  O_MEM_ADDR, O_MEM_WDATA, O_MEM_WE,
    output I_MEM_RDATA,
    input  O_READY
  );

endinterface

// File: rtl/fss_rr_arbiter2.sv
// Two-requester round-robin arbiter with a bounded peripheral burst lock.
// Grant is combinational; only the fairness pointer and burst length are state.
module fss_rr_arbiter2
  import fss_mem_pkg::*;
#(
  parameter int unsigned P_MAX_BURST = C_MAX_BURST
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       i_enable,
  input  logic       i_cpu_req,
  input  logic       i_per_req,
  input  logic       i_per_lock,
  output logic [1:0] o_gnt
);

  localparam int unsigned     C_BW        = count_width(P_MAX_BURST);
  localparam logic [C_BW-1:0] C_BURST_MAX = C_BW'(P_MAX_BURST);
  localparam logic [C_BW-1:0] C_BURST_ONE = C_BW'(1);

  logic [C_BW-1:0] r_burst_count;
  last_gnt_t       r_last_gnt;
  logic            w_locked;

  // Grant decision: lock first, then lone requester, then round-robin tie-break
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    o_gnt    = '0;
    // A non-zero burst count means the peripheral held the port last cycle.
    w_locked = (r_burst_count != '0) && (r_burst_count < C_BURST_MAX) &&
               i_per_req && i_per_lock;
    if (i_enable) begin
      if (w_locked) begin
        o_gnt[C_GNT_PER_BIT] = 1'b1;
      end else if (i_cpu_req && i_per_req) begin
        if (r_last_gnt == GNT_PER) o_gnt[C_GNT_CPU_BIT] = 1'b1;
        else                       o_gnt[C_GNT_PER_BIT] = 1'b1;
      end else if (i_cpu_req) begin
        o_gnt[C_GNT_CPU_BIT] = 1'b1;
      end else if (i_per_req) begin
        o_gnt[C_GNT_PER_BIT] = 1'b1;
      end
    end
  end

  // Fairness pointer and saturating run length of consecutive peripheral grants
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_burst_count <= '0;
      r_last_gnt    <= GNT_PER;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      if (o_gnt[C_GNT_PER_BIT]) begin
        r_last_gnt <= GNT_PER;
        if (r_burst_count != C_BURST_MAX) r_burst_count <= r_burst_count + C_BURST_ONE;
      end else if (o_gnt[C_GNT_CPU_BIT]) begin
        r_last_gnt    <= GNT_CPU;
        r_burst_count <= '0;
      end else begin
        r_burst_count <= '0;
      end
    end
  end

endmodule

// File: rtl/fss_mem_arbiter.sv
// FSS BRAM port-A arbiter: warm-up hold-off, CPU/peripheral arbitration,
// address/data muxing, read-valid tracking and the CR16 stall enable.
module fss_mem_arbiter
  import fss_mem_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH    = C_DATA_WIDTH,
  parameter int unsigned P_ADDRESS_WIDTH = C_ADDRESS_WIDTH,
  parameter int unsigned P_WARMUP_CYCLES = C_WARMUP_CYCLES,
  parameter int unsigned P_MAX_BURST     = C_MAX_BURST
) (
  input  logic             I_CLK,
  input  logic             I_NRESET,
  fss_mem_arbiter_if.slave io_bus
);

  localparam int unsigned         C_WARM_W    = count_width(P_WARMUP_CYCLES);
  localparam logic [C_WARM_W-1:0] C_WARM_LAST = C_WARM_W'(P_WARMUP_CYCLES - 1);
  localparam logic [C_WARM_W-1:0] C_WARM_ONE  = C_WARM_W'(1);

  arb_state_t                 r_state;
  logic [C_WARM_W-1:0]        r_warm_cnt;
  logic                       r_ready;
  logic                       r_cpu_rvalid;
  logic                       r_per_rvalid;

  logic [1:0]                 w_gnt;
  logic [P_ADDRESS_WIDTH-1:0] w_mem_addr;
  logic [P_DATA_WIDTH-1:0]    w_mem_wdata;
  logic                       w_mem_we;

  // Warm-up sequencer: count settle cycles, then stay in RUN until reset
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state    <= WARMUP;
      r_warm_cnt <= '0;
      r_ready    <= 1'b0;
    end else if (r_state == WARMUP) begin
      if (r_warm_cnt == C_WARM_LAST) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end else begin
        r_warm_cnt <= r_warm_cnt + C_WARM_ONE;
      end
    end
  end

  fss_rr_arbiter2 #(
    .P_MAX_BURST (P_MAX_BURST)
  ) u_rr_arbiter2 (
    .I_CLK      (I_CLK),
    .I_NRESET   (I_NRESET),
    .i_enable   (r_ready),
    .i_cpu_req  (io_bus.I_CPU_REQ),
    .i_per_req  (io_bus.I_PER_REQ),
    .i_per_lock (io_bus.I_PER_LOCK),
    .o_gnt      (w_gnt)
  );

  // Port-A mux: route the granted master, drive zeros when the port is idle
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    if (w_gnt[C_GNT_CPU_BIT]) begin
      w_mem_addr  = io_bus.I_CPU_ADDR;
      w_mem_wdata = io_bus.I_CPU_WDATA;
      w_mem_we    = io_bus.I_CPU_WE;
    end else if (w_gnt[C_GNT_PER_BIT]) begin
      w_mem_addr  = io_bus.I_PER_ADDR;
      w_mem_wdata = io_bus.I_PER_WDATA;
      w_mem_we    = io_bus.I_PER_WE;
    end
  end

  // Read-valid tracking: BRAM returns data one cycle after a granted read
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_cpu_rvalid <= 1'b0;
      r_per_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_gnt[C_GNT_CPU_BIT] & ~io_bus.I_CPU_WE;
      r_per_rvalid <= w_gnt[C_GNT_PER_BIT] & ~io_bus.I_PER_WE;
    end
  end

  assign io_bus.O_CPU_GNT    = w_gnt[C_GNT_CPU_BIT];
  assign io_bus.O_PER_GNT    = w_gnt[C_GNT_PER_BIT];
  assign io_bus.O_MEM_ADDR   = w_mem_addr;
  assign io_bus.O_MEM_WDATA  = w_mem_wdata;
  assign io_bus.O_MEM_WE     = w_mem_we;
  assign io_bus.O_CPU_RVALID = r_cpu_rvalid;
  assign io_bus.O_PER_RVALID = r_per_rvalid;
  // Read data is shared; it is forced to zero until warm-up completes.
  assign io_bus.O_CPU_RDATA  = r_ready ? io_bus.I_MEM_RDATA : '0;
  assign io_bus.O_PER_RDATA  = r_ready ? io_bus.I_MEM_RDATA : '0;
  assign io_bus.O_READY      = r_ready;
  // The core stalls whenever it asks for the port and does not get it.
  assign io_bus.O_CPU_ENABLE = r_ready & (~io_bus.I_CPU_REQ | w_gnt[C_GNT_CPU_BIT]);

endmodule

// File: doc/fss_mem_arbiter.md
# fss_mem_arbiter

Arbitrates the single read/write port A of the FSS BRAM between the CR16 core and one peripheral master (synth voice engine or program loader). After reset it holds both masters off for a programmable BRAM warm-up period. It then grants at most one access per cycle with round-robin fairness and a bounded peripheral burst lock. It drives the CR16 enable so the core stalls, rather than being clock-gated, whenever it loses arbitration.

## Interface
- P_DATA_WIDTH, 16, BRAM word width
- P_ADDRESS_WIDTH, 11, BRAM address width
- P_WARMUP_CYCLES, 2, cycles after reset release before any grant (≥1)
- P_MAX_BURST, 8, max consecutive locked peripheral grants (≥1)
- I_CLK  in  1  clock; I_NRESET  in  1  reset, asynchronous, active-low
- I_CPU_REQ / I_CPU_WE  in  1  CPU access request / write enable
- I_CPU_ADDR  in  P_ADDRESS_WIDTH;  I_CPU_WDATA  in  P_DATA_WIDTH
- O_CPU_GNT  out  1  CPU access issued this cycle
- O_CPU_RVALID  out  1  O_CPU_RDATA valid (read granted previous cycle)
- O_CPU_RDATA  out  P_DATA_WIDTH  read data
- O_CPU_ENABLE  out  1  CR16 I_ENABLE; low = stall
- I_PER_REQ / I_PER_WE / I_PER_LOCK  in  1  request / write enable / keep grant
- I_PER_ADDR, I_PER_WDATA, O_PER_GNT, O_PER_RVALID, O_PER_RDATA: as CPU equivalents
- O_MEM_ADDR  out  P_ADDRESS_WIDTH;  O_MEM_WDATA  out  P_DATA_WIDTH;  O_MEM_WE  out  1  to BRAM port A
- I_MEM_RDATA  in  P_DATA_WIDTH  BRAM port A read data (1-cycle synchronous read)
- O_READY  out  1  warm-up complete

## Operation
- FSM: WARMUP → RUN. WARMUP counts P_WARMUP_CYCLES; no grants, O_READY=0. RUN is permanent until reset.
- RUN grant rules, in order:
  - Locked: previous grant was the peripheral, I_PER_REQ & I_PER_LOCK, and burst_count < P_MAX_BURST → peripheral.
  - Only one requester → that one.
  - Both request → the one not granted last (last_gnt pointer; reset value = PER, so CPU wins first tie).
- Burst cap: when burst_count reaches P_MAX_BURST and the CPU is requesting, the CPU gets the next grant. If the CPU is idle, the peripheral keeps the port and burst_count saturates.
- burst_count: increments on each consecutive peripheral grant; clears on any CPU grant or idle cycle.
- Grants are combinational from requests and state. O_MEM_* is muxed from the granted master. With no grant: O_MEM_ADDR=0, O_MEM_WDATA=0, O_MEM_WE=0.
- RVALID: registered copy of (GNT & ~WE) per master. RDATA: I_MEM_RDATA routed to both masters; only meaningful when RVALID.
- O_CPU_ENABLE = O_READY & (~I_CPU_REQ | O_CPU_GNT). CPU request signals must not depend combinationally on O_CPU_ENABLE.
- Masters hold REQ, WE, ADDR and WDATA stable until granted.

## Timing
- Reset (async): state=WARMUP, counters=0, last_gnt=PER, RVALIDs=0, O_READY=0. All combinational outputs evaluate to 0.
- O_READY rises on the clock edge P_WARMUP_CYCLES after I_NRESET deasserts; the first grant is possible in that cycle.
- Read latency: grant in cycle N → RVALID and data in cycle N+1.
- Writes complete at the granting edge; no RVALID.
- Back-to-back grants are allowed every cycle, to either master.
- Reset asserted mid-access: the access is dropped, RVALID clears immediately, and warm-up restarts.
- Simultaneous first requests after warm-up: CPU is granted.

## Structure
- Package fss_mem_pkg:
  - typedef enum {WARMUP, RUN} for the arbiter state.
  - typedef enum {GNT_CPU, GNT_PER} for last-grant.
  - Default width constants.
- Sub-module fss_rr_arbiter2: two-request round-robin with lock and burst counter, outputs one-hot grant. The top adds warm-up, muxing, RVALID and enable.

## Test plan
- Reset release, CPU requests continuously → O_READY and first O_CPU_GNT exactly 2 cycles after release; O_CPU_ENABLE=0 during warm-up.
- CPU read 0x005 (BRAM holds 0x1234) → O_CPU_RVALID=1 with O_CPU_RDATA=0x1234 one cycle after grant.
- Both masters request continuously, no lock → grants alternate CPU, PER, CPU, PER; O_CPU_ENABLE=0 on PER cycles.
- Peripheral locked burst with CPU requesting, P_MAX_BURST=8 → 8 PER grants, then 1 CPU grant, then PER resumes.
- PER write 0xBEEF to 0x010, then CPU read 0x010 → CPU receives 0xBEEF.
- I_NRESET pulsed low while a PER read is granted → O_PER_RVALID=0 immediately; no grants for 2 cycles after release.
